tt_sweep_ctrl: RTL and testbench
================================

Name: tt_sweep_ctrl

Overview:
- Sequencer that characterises one 3-input genetic-logic gate by sweeping all 8 input combinations.
- Drives in1/in2/in3 of the gate under test, waits a programmable settle time per vector and samples the gate output.
- Assembles the sampled outputs into an 8-bit truth-table code, compares it against an expected code (e.g. 8'hEC) and reports pass/fail.
- Sits between the gate netlist and the test/host controller.

Parameters:
- SETTLE_CYCLES, 3, number of extra cycles each vector is held before sampling; legal range 0..255.

Ports:
- clk  input  1  single clock, rising edge.
- reset_n  input  1  synchronous, active-low reset.
- start  input  1  single-cycle request to begin a sweep; only accepted in IDLE.
- abort  input  1  terminates a running sweep.
- expected  input  8  expected truth-table code; sampled when start is accepted.
- dut_out  input  1  output of the gate under test.
- in1  output  1  gate input 1 (MSB of vector code).
- in2  output  1  gate input 2.
- in3  output  1  gate input 3 (LSB of vector code).
- busy  output  1  high while a sweep is running.
- done  output  1  one-cycle pulse when a sweep completes normally.
- pass  output  1  high when the measured table equals expected; valid from done onward.
- tt_code  output  8  measured truth table.
- mismatch  output  8  tt_code XOR expected.

Behaviour:
- Reset (reset_n low at a clock edge):
  - State goes to IDLE.
  - in1/in2/in3, busy, done and pass go to 0.
  - tt_code and mismatch go to 8'h00.
  - Reset overrides every other input, including in the middle of a sweep.
- Vector code v = {in1,in2,in3}. The sample taken for vector v is written to tt_code bit (7 - v). Vector 000 maps to the MSB, so gate 0xEC yields tt_code = 8'hEC.
- States: IDLE, DRIVE, DONE.
- IDLE:
  - Outputs v = 000 and busy = 0.
  - start = 1 at an edge: latch expected, clear tt_code, set v = 000 and the settle counter to 0, go to DRIVE.
- DRIVE:
  - busy = 1. The counter increments every cycle.
  - When counter == SETTLE_CYCLES, dut_out is captured into bit (7 - v) at that edge and the counter resets to 0.
  - If v < 7: v increments.
  - If v == 7: go to DONE.
  - Each vector is therefore visible for SETTLE_CYCLES+1 cycles.
- DONE:
  - Lasts exactly 1 cycle: done = 1, busy = 0, v returns to 000.
  - pass and mismatch are registered from the complete tt_code.
  - Next state is IDLE.
- Latency: done goes high 8*(SETTLE_CYCLES+1) cycles after the start-accept edge.
- Results (tt_code, pass, mismatch) hold until the next accepted start. On that start, pass clears to 0 and mismatch clears to 8'h00.
- start while in DRIVE or DONE is ignored; it is not queued.
- abort = 1 in DRIVE: next state IDLE, no done pulse, pass = 0. tt_code keeps the bits captured so far; bits not yet sampled are 0.
- abort in IDLE or DONE has no effect.
- If abort and start are high together in IDLE, start wins (abort is meaningless in IDLE).
- dut_out is sampled only at the capture edge; its value at any other time is ignored.

Optional Feature:
- Macro: TT_SWEEP_VOTE_EN.
- Defined:
  - The capture uses a 2-of-3 majority of dut_out over the last three cycles of each vector window (counter == SETTLE_CYCLES-2, SETTLE_CYCLES-1, SETTLE_CYCLES).
  - Requires SETTLE_CYCLES >= 2. Elaboration must fail otherwise.
  - Latency is unchanged.
- Undefined:
  - Single-cycle capture at counter == SETTLE_CYCLES.
  - No vote registers are present.

Test Plan:
- SETTLE_CYCLES=3, bench models gate 0xEC, expected = 8'hEC, start pulse -> busy for 32 cycles; each vector held 4 cycles in order 000..111; done at cycle 32; tt_code = 8'hEC, pass = 1, mismatch = 8'h00.
- Same run with expected = 8'hE8 -> tt_code = 8'hEC, pass = 0, mismatch = 8'h04.
- start re-pulsed at cycle 10 of a sweep -> ignored; done still at cycle 32 and exactly one done pulse.
- abort at cycle 9 (vectors 000 and 001 already captured) -> IDLE next cycle, no done, pass = 0, tt_code = 8'hC0.
- reset_n low at cycle 20 of a sweep -> all outputs 0 on the next edge; a new start then runs a full clean sweep.
- TT_SWEEP_VOTE_EN defined, SETTLE_CYCLES=3, dut_out glitches to 0 for one cycle inside the sample window of vector 000 -> tt_code = 8'hEC, pass = 1. Without the macro, the same glitch placed on the capture edge gives tt_code = 8'h6C.

Source files
------------

// File: rtl/tt_sweep_ctrl.sv
// tt_sweep_ctrl: truth-table sweep sequencer for one 3-input gate.
// Optional: define TT_SWEEP_VOTE_EN for 2-of-3 majority capture.
module tt_sweep_ctrl #(
    parameter int unsigned SETTLE_CYCLES = 3
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       start,
    input  logic       abort,
    input  logic [7:0] expected,
    input  logic       dut_out,
    output logic       in1,
    output logic       in2,
    output logic       in3,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [7:0] tt_code,
    output logic [7:0] mismatch
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [7:0] SETTLE = 8'(SETTLE_CYCLES);

    state_t     state_q;
    state_t     state_d;
    logic [2:0] vec_q;
    logic [7:0] cnt_q;
    logic [7:0] tt_q;
    logic [7:0] exp_q;
    logic [7:0] mis_q;
    logic       pass_q;

    logic       win_end;
    logic       capture;
    logic       last_vec;
    logic       sample_bit;
    logic [7:0] tt_cap;

`ifdef TT_SWEEP_VOTE_EN
    // The vote looks back two cycles, so the window must hold them.
    if (SETTLE_CYCLES < 2) begin : g_bad_settle
        $error("tt_sweep_ctrl: SETTLE_CYCLES must be >= 2 with voting");
    end

    logic hist1_q;
    logic hist2_q;

    // Two-deep history of dut_out for the majority vote.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            hist1_q <= 1'b0;
            hist2_q <= 1'b0;
        end else begin
            hist1_q <= dut_out;
            hist2_q <= hist1_q;
        end
    end

    assign sample_bit = (dut_out & hist1_q) |
                        (dut_out & hist2_q) |
                        (hist1_q & hist2_q);
`else
    assign sample_bit = dut_out;
`endif

    assign win_end  = (cnt_q == SETTLE);
    assign last_vec = (vec_q == 3'd7);
    assign capture  = (state_q == DRIVE) && !abort && win_end;

    // Current table with this vector's sample merged into bit 7-v.
    always_comb begin
        tt_cap = tt_q;
        tt_cap[3'd7 - vec_q] = sample_bit;
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and status decode.
    always_comb begin
        state_d = state_q;
        busy    = 1'b0;
        done    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = DRIVE;
                end
            end
            DRIVE: begin
                busy = 1'b1;
                if (abort) begin
                    state_d = IDLE;
                end else if (capture && last_vec) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Vector/counter sequencing and result registers.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            vec_q  <= 3'd0;
            cnt_q  <= 8'd0;
            tt_q   <= 8'h00;
            exp_q  <= 8'h00;
            mis_q  <= 8'h00;
            pass_q <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (start) begin
                        exp_q  <= expected;
                        tt_q   <= 8'h00;
                        mis_q  <= 8'h00;
                        pass_q <= 1'b0;
                        vec_q  <= 3'd0;
                        cnt_q  <= 8'd0;
                    end
                end
                DRIVE: begin
                    if (abort) begin
                        vec_q <= 3'd0;
                        cnt_q <= 8'd0;
                    end else if (win_end) begin
                        tt_q  <= tt_cap;
                        cnt_q <= 8'd0;
                        if (last_vec) begin
                            // Final sample: grade the full table now
                            // so pass is valid alongside done.
                            vec_q  <= 3'd0;
                            pass_q <= (tt_cap == exp_q);
                            mis_q  <= tt_cap ^ exp_q;
                        end else begin
                            vec_q <= vec_q + 3'd1;
                        end
                    end else begin
                        cnt_q <= cnt_q + 8'd1;
                    end
                end
                DONE: begin
                    vec_q <= 3'd0;
                end
                default: begin
                    vec_q <= 3'd0;
                end
            endcase
        end
    end

    assign in1      = vec_q[2];
    assign in2      = vec_q[1];
    assign in3      = vec_q[0];
    assign pass     = pass_q;
    assign tt_code  = tt_q;
    assign mismatch = mis_q;

endmodule

// File: tb/tb_tt_sweep_ctrl.sv
// tb_tt_sweep_ctrl: self-checking bench for tt_sweep_ctrl.
// Models the gate under test and predicts each sweep's outcome.
module tb_tt_sweep_ctrl;

    localparam int S = 3;
    localparam int W = S + 1;
    localparam int L = 8 * W;

`ifdef TT_SWEEP_VOTE_EN
    localparam bit VOTE = 1'b1;
`else
    localparam bit VOTE = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic [7:0] expected = 8'h00;
    logic       dut_out;
    logic       in1, in2, in3;
    logic       busy, done, pass;
    logic [7:0] tt_code, mismatch;

    logic [7:0] gate = 8'hEC;
    logic       glitch = 1'b0;
    logic [2:0] vec_o;

    int n_vec = 0;
    int n_err = 0;

    tt_sweep_ctrl #(.SETTLE_CYCLES(S)) u_dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .start    (start),
        .abort    (abort),
        .expected (expected),
        .dut_out  (dut_out),
        .in1      (in1),
        .in2      (in2),
        .in3      (in3),
        .busy     (busy),
        .done     (done),
        .pass     (pass),
        .tt_code  (tt_code),
        .mismatch (mismatch)
    );

    always #5 clk = ~clk;

    // Gate under test: truth-table lookup, optionally inverted.
    assign vec_o   = {in1, in2, in3};
    assign dut_out = gate[3'd7 - vec_o] ^ glitch;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs,
                       input logic [7:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle_zero(input string tag);
        chk({tag, "_busy"}, {7'd0, busy}, 8'd0);
        chk({tag, "_done"}, {7'd0, done}, 8'd0);
        chk({tag, "_vec"}, {5'd0, vec_o}, 8'd0);
    endtask

    // One sweep; *_k selects the cycle index (after the start edge)
    // at which an event is driven, -1 for none.
    task automatic sweep(input logic [7:0] g, input logic [7:0] e,
                         input int abort_k, input int glitch_k,
                         input int restart_k, input int reset_k,
                         input bit abort_at_start);
        logic [7:0] tt_m;
        bit         samp [0:L-1];
        int         vexp;
        int         ones;
        gate     = g;
        expected = e;
        start    = 1'b1;
        abort    = abort_at_start;
        tick();
        start    = 1'b0;
        abort    = 1'b0;
        expected = 8'($urandom);
        tt_m     = 8'h00;
        chk("clr_tt", tt_code, 8'h00);
        chk("clr_pass", {7'd0, pass}, 8'd0);
        chk("clr_mis", mismatch, 8'h00);
        for (int k = 0; k < L; k++) begin
            vexp = k / W;
            chk("busy", {7'd0, busy}, 8'd1);
            chk("done_early", {7'd0, done}, 8'd0);
            chk("vec", {5'd0, vec_o}, 8'(vexp));
            start   = (k == restart_k);
            abort   = (k == abort_k);
            glitch  = (k == glitch_k);
            reset_n = !(k == reset_k);
            samp[k] = g[7 - vexp] ^ (k == glitch_k);
            if (k == abort_k || k == reset_k) begin
                tick();
                start = 1'b0; abort = 1'b0;
                glitch = 1'b0; reset_n = 1'b1;
                chk_idle_zero("stop");
                chk("stop_pass", {7'd0, pass}, 8'd0);
                chk("stop_mis", mismatch, 8'h00);
                chk("stop_tt", tt_code, (k == reset_k) ? 8'h00 : tt_m);
                tick();
                chk("stop_nodone", {7'd0, done}, 8'd0);
                return;
            end
            if (k % W == S) begin
                if (VOTE) begin
                    ones = samp[k] + samp[k-1] + samp[k-2];
                    tt_m[7 - vexp] = (ones >= 2);
                end else begin
                    tt_m[7 - vexp] = samp[k];
                end
            end
            tick();
            start = 1'b0; abort = 1'b0; glitch = 1'b0;
        end
        chk("done", {7'd0, done}, 8'd1);
        chk("done_busy", {7'd0, busy}, 8'd0);
        chk("done_vec", {5'd0, vec_o}, 8'd0);
        chk("tt", tt_code, tt_m);
        chk("pass", {7'd0, pass}, {7'd0, tt_m == e});
        chk("mis", mismatch, tt_m ^ e);
        tick();
        chk_idle_zero("after");
        chk("hold_tt", tt_code, tt_m);
        chk("hold_pass", {7'd0, pass}, {7'd0, tt_m == e});
        chk("hold_mis", mismatch, tt_m ^ e);
    endtask

    initial begin
        logic [7:0] rg;
        logic [7:0] re;
        reset_n = 1'b0;
        tick();
        tick();
        chk_idle_zero("rst");
        chk("rst_pass", {7'd0, pass}, 8'd0);
        chk("rst_tt", tt_code, 8'h00);
        chk("rst_mis", mismatch, 8'h00);
        reset_n = 1'b1;
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk_idle_zero("idle_abort");
        tick();

        sweep(8'hEC, 8'hEC, -1, -1, -1, -1, 1'b0);
        sweep(8'hEC, 8'hE8, -1, -1, -1, -1, 1'b0);
        sweep(8'hEC, 8'hEC, -1, -1, 10, -1, 1'b0);
        sweep(8'hEC, 8'hEC, 9, -1, -1, -1, 1'b0);
        chk("abort_tt_c0", tt_code, 8'hC0);
        sweep(8'hEC, 8'hEC, -1, -1, -1, 20, 1'b0);
        chk("reset_tt", tt_code, 8'h00);
        sweep(8'hEC, 8'hEC, -1, -1, -1, -1, 1'b0);
        sweep(8'hEC, 8'hEC, -1, 3, -1, -1, 1'b0);
        chk("glitch_tt", tt_code, VOTE ? 8'hEC : 8'h6C);
        sweep(8'h5A, 8'h5A, -1, 2, -1, -1, 1'b1);
        sweep(8'h96, 8'h96, -1, 1 + 3 * W, -1, -1, 1'b0);

        for (int i = 0; i < 6; i++) begin
            rg = 8'($urandom);
            re = ($urandom_range(0, 1) == 1) ? rg : 8'($urandom);
            sweep(rg, re, -1, $urandom_range(0, L - 1), -1, -1, 1'b0);
            tick();
        end
        rg = 8'($urandom);
        sweep(rg, rg, $urandom_range(0, L - 1), -1, -1, -1, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
